// File: rtl/fetch_ifid_stage.sv
// -----------------------------------------------------------------------------
// fetch_ifid_stage
//   Instruction-fetch stage and IF/ID pipeline register for the 16-bit,
//   4-bit-opcode pipelined core. Owns the PC, drives the instruction-memory
//   address, latches fetched words into IF/ID and decodes the opcode, source
//   and destination register fields for the load-use hazard detector.
//   Honours hazard stalls and branch-redirect flushes, freezes fetch on HLT
//   and keeps saturating stall/flush event counters.
//
// Ports:
//   clk            in   clock, all state updates on rising edge
//   rst            in   synchronous active-high reset
//   stall_en       in   load-use stall: hold PC and IF/ID
//   br_taken       in   branch resolved taken in ID: redirect fetch
//   br_target      in   redirect PC (bit 0 ignored)
//   imem_addr      out  instruction-memory address (= pc)
//   imem_data      in   instruction word, combinational from imem_addr
//   if_id_instr    out  latched instruction
//   if_id_pc_plus2 out  PC+2 of the latched instruction
//   if_id_valid    out  1 = real instruction, 0 = bubble
//   dec_opcode     out  opcode field, 0 when invalid
//   srcReg1        out  first source register, 0 when invalid
//   srcReg2        out  second source register, 0 when invalid
//   dstReg         out  destination register, 0 when invalid
//   halted         out  HLT has reached IF/ID, core stopping
//   stall_cnt      out  honoured stall cycles (saturating)
//   flush_cnt      out  branch redirects taken (saturating)
// -----------------------------------------------------------------------------
module fetch_ifid_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          CNT_W      = 16,
    parameter logic [3:0]  HLT_OPCODE = 4'b1111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_en,
    input  logic             br_taken,
    input  logic [15:0]      br_target,
    output logic [15:0]      imem_addr,
    input  logic [15:0]      imem_data,
    output logic [15:0]      if_id_instr,
    output logic [15:0]      if_id_pc_plus2,
    output logic             if_id_valid,
    output logic [3:0]       dec_opcode,
    output logic [3:0]       srcReg1,
    output logic [3:0]       srcReg2,
    output logic [3:0]       dstReg,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [15:0]      instr_q, instr_d;
    logic [15:0]      pcp2_q, pcp2_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [15:0]      pc_plus2_s;
    logic             if_id_is_hlt_s;

    // 16-bit modulo increment; FFFE wraps to 0000.
    assign pc_plus2_s     = pc_q + 16'd2;
    assign if_id_is_hlt_s = valid_q && (instr_q[15:12] == HLT_OPCODE);

    // Next-state logic: priority stall > redirect > halt > normal fetch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcp2_d      = pcp2_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (stall_en) begin
            // Everything holds; a concurrent br_taken re-resolves next cycle.
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (br_taken) begin
            // Redirect squashes IF/ID, including a speculatively fetched HLT.
            pc_d        = br_target & 16'hFFFE;
            instr_d     = 16'h0000;
            pcp2_d      = 16'h0000;
            valid_d     = 1'b0;
            halted_d    = 1'b0;
            state_d     = ST_RUN;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            case (state_q)
                ST_RUN: begin
                    instr_d = imem_data;
                    pcp2_d  = pc_plus2_s;
                    valid_d = 1'b1;
                    if (imem_data[15:12] == HLT_OPCODE) begin
                        // PC freezes on the HLT so nothing past it is fetched.
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_plus2_s;
                    end
                end
                ST_HALT: begin
                    if (if_id_is_hlt_s) begin
                        instr_d  = 16'h0000;
                        pcp2_d   = 16'h0000;
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        halted_d = halted_q;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State register with synchronous reset overriding all other inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC & 16'hFFFE;
            instr_q     <= 16'h0000;
            pcp2_q      <= 16'h0000;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcp2_q      <= pcp2_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Decode fields from IF/ID; all zero for a bubble.
    always_comb begin
        dec_opcode = 4'h0;
        srcReg1    = 4'h0;
        srcReg2    = 4'h0;
        dstReg     = 4'h0;
        if (valid_q) begin
            dec_opcode = instr_q[15:12];
            dstReg     = instr_q[11:8];
            case (instr_q[15:12])
                4'b1010, 4'b1011: srcReg1 = instr_q[11:8]; // LLB/LHB read rd
                default:          srcReg1 = instr_q[7:4];
            endcase
            case (instr_q[15:12])
                4'b1001: srcReg2 = instr_q[11:8];          // SW reads data reg
                default: srcReg2 = instr_q[3:0];
            endcase
        end else begin
            dec_opcode = 4'h0;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus2 = pcp2_q;
    assign if_id_valid    = valid_q;
    assign halted         = halted_q;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
module tb_fetch_ifid_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_en;
    logic          br_taken;
    logic [15:0]   br_target;
    logic [15:0]   imem_addr;
    logic [15:0]   imem_data;
    logic [15:0]   if_id_instr;
    logic [15:0]   if_id_pc_plus2;
    logic          if_id_valid;
    logic [3:0]    dec_opcode;
    logic [3:0]    srcReg1;
    logic [3:0]    srcReg2;
    logic [3:0]    dstReg;
    logic          halted;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    logic [15:0] mem [0:32767];
    assign imem_data = mem[imem_addr[15:1]];

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pcp2;
        logic        valid;
        logic        hlt;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_ifid_stage #(
        .RESET_PC   (16'h0000),
        .CNT_W      (CW),
        .HLT_OPCODE (4'b1111)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_en       (stall_en),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .dec_opcode     (dec_opcode),
        .srcReg1        (srcReg1),
        .srcReg2        (srcReg2),
        .dstReg         (dstReg),
        .halted         (halted),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; stall_en = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_en = 1'b1; br_taken = 1'b1; br_target = 16'h1234;
        step();
        rst = 1'b0; stall_en = 1'b0; br_taken = 1'b0;
        vectors++;
        if ({imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, dec_opcode, stall_cnt, flush_cnt}
            !== {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0}) begin
            miscompares++;
            $display("FAIL reset: got addr=%h instr=%h pc2=%h v=%b h=%b op=%h sc=%0d fc=%0d, expected all zero",
                     imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, dec_opcode, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_run();
        mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h0000;
        apply_reset();
        sb_q.push_back('{"run_c0", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0});
        sb_q.push_back('{"run_c1", 16'h0002, 16'h1123, 16'h0002, 1'b1, 1'b0});
        sb_q.push_back('{"run_c2", 16'h0004, 16'h2456, 16'h0004, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            e = sb_q.pop_front();
            vectors++;
            if ({imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted} !== {e.addr, e.instr, e.pcp2, e.valid, e.hlt}) begin
                miscompares++;
                $display("FAIL %s: got addr=%h instr=%h pc2=%h v=%b h=%b, expected addr=%h instr=%h pc2=%h v=%b h=%b",
                         e.name, imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, e.addr, e.instr, e.pcp2, e.valid, e.hlt);
            end
        end
    endtask

    task automatic test_stall();
        mem[0] = 16'h8120; mem[1] = 16'h0123;
        apply_reset();
        sb_q.push_back('{"stall_load", 16'h0002, 16'h8120, 16'h0002, 1'b1, 1'b0});
        sb_q.push_back('{"stall_c1",   16'h0002, 16'h8120, 16'h0002, 1'b1, 1'b0});
        sb_q.push_back('{"stall_c2",   16'h0002, 16'h8120, 16'h0002, 1'b1, 1'b0});
        sb_q.push_back('{"stall_rel",  16'h0004, 16'h0123, 16'h0004, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++) begin
            stall_en = (i == 1 || i == 2);
            step();
            e = sb_q.pop_front();
            vectors++;
            if ({imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted} !== {e.addr, e.instr, e.pcp2, e.valid, e.hlt}) begin
                miscompares++;
                $display("FAIL %s: got addr=%h instr=%h pc2=%h v=%b h=%b, expected addr=%h instr=%h pc2=%h v=%b h=%b",
                         e.name, imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, e.addr, e.instr, e.pcp2, e.valid, e.hlt);
            end
        end
        stall_en = 1'b0;
        vectors++;
        if (stall_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_flush();
        mem[0] = 16'h1123; mem[16'h20] = 16'h2456; mem[16'h21] = 16'h0000;
        apply_reset();
        step();
        br_taken = 1'b1; br_target = 16'h0040;
        step();
        br_taken = 1'b0;
        vectors++;
        if ({imem_addr, if_id_valid, dec_opcode, if_id_instr, flush_cnt} !== {16'h0040, 1'b0, 4'h0, 16'h0000, 4'd1}) begin
            miscompares++;
            $display("FAIL flush: got addr=%h v=%b op=%h instr=%h fc=%0d, expected addr=0040 v=0 op=0 instr=0000 fc=1",
                     imem_addr, if_id_valid, dec_opcode, if_id_instr, flush_cnt);
        end
        sb_q.push_back('{"flush_fetch",  16'h0042, 16'h2456, 16'h0042, 1'b1, 1'b0});
        sb_q.push_back('{"flush_stalled", 16'h0042, 16'h2456, 16'h0042, 1'b1, 1'b0});
        sb_q.push_back('{"flush_resume", 16'h0044, 16'h0000, 16'h0044, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            stall_en = (i == 1); br_taken = (i == 1); br_target = 16'h0080;
            step();
            e = sb_q.pop_front();
            vectors++;
            if ({imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted} !== {e.addr, e.instr, e.pcp2, e.valid, e.hlt}) begin
                miscompares++;
                $display("FAIL %s: got addr=%h instr=%h pc2=%h v=%b h=%b, expected addr=%h instr=%h pc2=%h v=%b h=%b",
                         e.name, imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, e.addr, e.instr, e.pcp2, e.valid, e.hlt);
            end
        end
        stall_en = 1'b0; br_taken = 1'b0;
        vectors++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd1}) begin
            miscompares++;
            $display("FAIL flush_stall_cnt: got fc=%0d sc=%0d expected fc=1 sc=1", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_halt();
        mem[0] = 16'h1123; mem[1] = 16'hF000; mem[8] = 16'h2456;
        apply_reset();
        sb_q.push_back('{"halt_pre",    16'h0002, 16'h1123, 16'h0002, 1'b1, 1'b0});
        sb_q.push_back('{"halt_fetch",  16'h0002, 16'hF000, 16'h0004, 1'b1, 1'b0});
        sb_q.push_back('{"halt_set",    16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b1});
        sb_q.push_back('{"halt_hold",   16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b1});
        sb_q.push_back('{"halt_squash", 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0});
        sb_q.push_back('{"halt_resume", 16'h0012, 16'h2456, 16'h0012, 1'b1, 1'b0});
        for (int i = 0; i < 6; i++) begin
            br_taken = (i == 4); br_target = 16'h0010;
            step();
            e = sb_q.pop_front();
            vectors++;
            if ({imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted} !== {e.addr, e.instr, e.pcp2, e.valid, e.hlt}) begin
                miscompares++;
                $display("FAIL %s: got addr=%h instr=%h pc2=%h v=%b h=%b, expected addr=%h instr=%h pc2=%h v=%b h=%b",
                         e.name, imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, e.addr, e.instr, e.pcp2, e.valid, e.hlt);
            end
        end
        br_taken = 1'b0;
    endtask

    task automatic test_decode();
        logic [15:0] exp_q[$];
        logic [15:0] d;
        mem[0] = 16'h9345; mem[1] = 16'hB7AA; mem[2] = 16'h0123;
        apply_reset();
        // packed as {opcode, src1, src2, dst}
        exp_q.push_back({4'h9, 4'h4, 4'h3, 4'h3});
        exp_q.push_back({4'hB, 4'h7, 4'hA, 4'h7});
        exp_q.push_back({4'h0, 4'h2, 4'h3, 4'h1});
        for (int i = 0; i < 3; i++) begin
            step();
            d = exp_q.pop_front();
            vectors++;
            if ({dec_opcode, srcReg1, srcReg2, dstReg} !== d) begin
                miscompares++;
                $display("FAIL decode_%0d: got op/s1/s2/d=%h expected %h (instr=%h)",
                         i, {dec_opcode, srcReg1, srcReg2, dstReg}, d, if_id_instr);
            end
        end
    endtask

    task automatic test_boundary();
        mem[16'h7FFF] = 16'h1123; mem[0] = 16'hF000;
        apply_reset();
        br_taken = 1'b1; br_target = 16'hFFFF;
        sb_q.push_back('{"wrap_redirect", 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0});
        sb_q.push_back('{"wrap_fetch",    16'h0000, 16'h1123, 16'h0000, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            step();
            br_taken = 1'b0;
            e = sb_q.pop_front();
            vectors++;
            if ({imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted} !== {e.addr, e.instr, e.pcp2, e.valid, e.hlt}) begin
                miscompares++;
                $display("FAIL %s: got addr=%h instr=%h pc2=%h v=%b h=%b, expected addr=%h instr=%h pc2=%h v=%b h=%b",
                         e.name, imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, e.addr, e.instr, e.pcp2, e.valid, e.hlt);
            end
        end
        stall_en = 1'b1;
        for (int i = 0; i < 20; i++) step();
        stall_en = 1'b0;
        vectors++;
        if ({stall_cnt, imem_addr, if_id_instr} !== {4'd15, 16'h0000, 16'h1123}) begin
            miscompares++;
            $display("FAIL stall_sat: got sc=%0d addr=%h instr=%h expected sc=15 addr=0000 instr=1123",
                     stall_cnt, imem_addr, if_id_instr);
        end
        step();
        step();
        vectors++;
        if ({halted, imem_addr, if_id_valid} !== {1'b1, 16'h0000, 1'b0}) begin
            miscompares++;
            $display("FAIL halt_before_rst: got h=%b addr=%h v=%b expected h=1 addr=0000 v=0",
                     halted, imem_addr, if_id_valid);
        end
        rst = 1'b1; stall_en = 1'b1; br_taken = 1'b1; br_target = 16'h0040;
        step();
        rst = 1'b0; stall_en = 1'b0; br_taken = 1'b0;
        vectors++;
        if ({imem_addr, if_id_valid, halted, stall_cnt, flush_cnt} !== {16'h0000, 1'b0, 1'b0, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL rst_from_halt: got addr=%h v=%b h=%b sc=%0d fc=%0d expected addr=0000 v=0 h=0 sc=0 fc=0",
                     imem_addr, if_id_valid, halted, stall_cnt, flush_cnt);
        end
        step();
        vectors++;
        if ({if_id_instr, if_id_pc_plus2, if_id_valid} !== {16'hF000, 16'h0002, 1'b1}) begin
            miscompares++;
            $display("FAIL run_after_rst: got instr=%h pc2=%h v=%b expected instr=F000 pc2=0002 v=1",
                     if_id_instr, if_id_pc_plus2, if_id_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        rst = 1'b1; stall_en = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
        test_reset();
        test_run();
        test_stall();
        test_flush();
        test_halt();
        test_decode();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
